// File: rtl/jpeg_arith_pkg.sv
// jpeg_arith_pkg: shared mode type, width helpers and stage-count function for the JPEG add/sub datapath
package jpeg_arith_pkg;
  typedef struct packed {
    logic sub;
    logic sgn;
    logic sat;
  } mode_t;
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction
  function automatic logic [63:0] ones(input int w);
    return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [63:0] smax(input int w);
    return ones(w) >> 1;
  endfunction
  function automatic logic [63:0] smin(input int w);
    return 64'd1 << (w - 1);
  endfunction
  localparam int WIDTH_DEF = 16;
  localparam int SEG_DEF = 4;
  localparam int STAGES = ceil_div(WIDTH_DEF, SEG_DEF);
endpackage

// File: rtl/jpeg_addsub_seg.sv
// jpeg_addsub_seg: combinational ripple segment producing sum, carry out and carry into its MSB
module jpeg_addsub_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign c_msb = sum[W-1] ^ a[W-1] ^ b[W-1];
endmodule

// File: rtl/jpeg_pipe_addsub.sv
// jpeg_pipe_addsub: segmented-carry pipelined add/sub with per-beat modes, saturation and valid/ready handshake
module jpeg_pipe_addsub
  import jpeg_arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_sat_hit
);
  localparam int NST = ceil_div(WIDTH, SEG);
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
  localparam logic [WIDTH-1:0] ONES = WIDTH'(ones(WIDTH));
  logic en, acc;
  assign en = !out_valid || out_ready;
  assign in_ready = en && !rst;
  assign acc = in_valid && in_ready;
  for (genvar k = 0; k < NST; k++) begin : g_st
    localparam int LO = k * SEG;
    localparam int W = (WIDTH - LO < SEG) ? WIDTH - LO : SEG;
    logic vi, ci, sc;
    mode_t mi;
    logic [WIDTH-LO-1:0] ah, bh;
    logic [W-1:0] ss;
    logic [LO+W-1:0] sn;
    if (k == 0) begin : g_in
      assign vi = acc;
      assign mi = {in_sub, in_signed, in_sat};
      assign ah = in_a;
      assign bh = in_sub ? ~in_b : in_b;
      assign ci = in_sub;
      assign sn = ss;
    end else begin : g_nx
      assign vi = g_st[k-1].g_mid.v_q;
      assign mi = g_st[k-1].g_mid.m_q;
      assign ah = g_st[k-1].g_mid.a_q;
      assign bh = g_st[k-1].g_mid.b_q;
      assign ci = g_st[k-1].g_mid.c_q;
      assign sn = {ss, g_st[k-1].g_mid.s_q};
    end
    if (k < NST - 1) begin : g_mid
      logic v_q, c_q, cm_unused;
      mode_t m_q;
      logic [WIDTH-LO-W-1:0] a_q, b_q;
      logic [LO+W-1:0] s_q;
      jpeg_addsub_seg #(.W(W)) u_seg (
        .a    (ah[W-1:0]),
        .b    (bh[W-1:0]),
        .cin  (ci),
        .sum  (ss),
        .cout (sc),
        .c_msb(cm_unused)
      );
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
          m_q <= '0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
        end else if (en) begin
          v_q <= vi;
          m_q <= mi;
          a_q <= ah[WIDTH-LO-1:W];
          b_q <= bh[WIDTH-LO-1:W];
          s_q <= sn;
          c_q <= sc;
        end
      end
    end else begin : g_out
      logic sm, ovf;
      logic [WIDTH-1:0] sv;
      jpeg_addsub_seg #(.W(W)) u_seg (
        .a    (ah[W-1:0]),
        .b    (bh[W-1:0]),
        .cin  (ci),
        .sum  (ss),
        .cout (sc),
        .c_msb(sm)
      );
      assign ovf = mi.sgn ? sm ^ sc : mi.sub ^ sc;
      assign sv = mi.sgn ? (sn[WIDTH-1] ? SMAX : SMIN) : (mi.sub ? '0 : ONES);
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_sum <= '0;
          out_cout <= 1'b0;
          out_ovf <= 1'b0;
          out_sat_hit <= 1'b0;
        end else if (en) begin
          out_valid <= vi;
          out_sum <= (mi.sat && ovf) ? sv : sn;
          out_cout <= sc;
          out_ovf <= ovf;
          out_sat_hit <= mi.sat && ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_jpeg_pipe_addsub.sv
// tb_jpeg_pipe_addsub: scoreboard bench for the pipelined add/sub unit at WIDTH=16, SEG=4
module tb_jpeg_pipe_addsub;
  typedef struct packed {
    logic [15:0] sum;
    logic cout;
    logic ovf;
    logic hit;
  } res_t;
  typedef struct {
    res_t r;
    int cyc;
    int st;
  } ent_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sub, in_signed, in_sat;
  logic out_valid, out_ready, out_cout, out_ovf, out_sat_hit;
  logic [15:0] in_a, in_b, out_sum;
  int vectors = 0, miscompares = 0, cyc = 0, stalls = 0;
  ent_t q[$];
  logic held = 1'b0;
  res_t h;
  always #5 clk = ~clk;
  jpeg_pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_signed(in_signed), .in_sat(in_sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_sat_hit(out_sat_hit)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sgn, input logic sat);
    res_t r;
    logic [16:0] u;
    int v;
    u = sub ? 17'(a) - 17'(b) : 17'(a) + 17'(b);
    v = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    r.cout = sub ? (a >= b) : u[16];
    r.ovf = sgn ? (v > 32767 || v < -32768) : (sub ? (a < b) : u[16]);
    r.hit = sat && r.ovf;
    r.sum = !r.hit ? u[15:0] : sgn ? (v > 32767 ? 16'h7fff : 16'h8000) : (sub ? 16'h0000 : 16'hffff);
    return r;
  endfunction
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      check("in_ready_en", 32'(in_ready), 32'(!out_valid || out_ready));
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum", 32'(out_sum), 32'(h.sum));
        check("hold_flags", 32'({out_cout, out_ovf, out_sat_hit}), 32'({h.cout, h.ovf, h.hit}));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
        else begin
          e = q.pop_front();
          check("sum", 32'(out_sum), 32'(e.r.sum));
          check("cout", 32'(out_cout), 32'(e.r.cout));
          check("ovf", 32'(out_ovf), 32'(e.r.ovf));
          check("sat_hit", 32'(out_sat_hit), 32'(e.r.hit));
          if (e.st == stalls) check("latency", 32'(cyc - e.cyc), 32'd4);
        end
      end
      if (in_valid && in_ready) begin
        e.r = model(in_a, in_b, in_sub, in_signed, in_sat);
        e.cyc = cyc;
        e.st = stalls;
        q.push_back(e);
      end
      held = out_valid && !out_ready;
      h = '{out_sum, out_cout, out_ovf, out_sat_hit};
      if (held) stalls++;
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic sgn, input logic sat);
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_signed = sgn;
    in_sat = sat;
    in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain;
    in_valid = 1'b0;
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 16'h0001;
    in_b = 16'h0001;
    in_sub = 1'b0;
    in_signed = 1'b0;
    in_sat = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_sum", 32'(out_sum), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    idle(6);
    send(16'h0fff, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'hffff, 16'h0001, 1'b0, 1'b0, 1'b0);
    send(16'hffff, 16'h0001, 1'b0, 1'b0, 1'b1);
    drain();
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0);
    send(16'h7fff, 16'h0001, 1'b0, 1'b1, 1'b1);
    send(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1);
    send(16'h7fff, 16'h8000, 1'b1, 1'b1, 1'b1);
    send(16'h8000, 16'hffff, 1'b0, 1'b1, 1'b0);
    drain();
    fork
      for (int i = 0; i < 10; i++)
        send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    send(16'h1234, 16'h0f0f, 1'b0, 1'b0, 1'b0);
    idle(1);
    send(16'h4000, 16'h5000, 1'b0, 1'b1, 1'b1);
    idle(1);
    drain();
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b0);
    send(16'h5555, 16'h6666, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(out_valid), 32'd0);
    idle(6);
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
